// File: rtl/pg_regs_pkg.sv
// Shared register-map constants and byte-lane helpers for the pulse-generator register bank.
package pg_regs_pkg;

  localparam int CH_STRIDE = 16;
  localparam int CH_IDX_W  = 3;
  localparam int BYTE_W    = 8;
  localparam int ENA_W     = 8;
  localparam int TIME_W    = 56;
  localparam int WIDTH_W   = 32;

  localparam logic [3:0] OFF_ENA      = 4'd0;
  localparam logic [3:0] OFF_YEAR_H   = 4'd1;
  localparam logic [3:0] OFF_YEAR_L   = 4'd2;
  localparam logic [3:0] OFF_MONTH    = 4'd3;
  localparam logic [3:0] OFF_DAY      = 4'd4;
  localparam logic [3:0] OFF_HOUR     = 4'd5;
  localparam logic [3:0] OFF_MINUTES  = 4'd6;
  localparam logic [3:0] OFF_SECONDS  = 4'd7;
  localparam logic [3:0] OFF_HIGH_3   = 4'd8;
  localparam logic [3:0] OFF_HIGH_2   = 4'd9;
  localparam logic [3:0] OFF_HIGH_1   = 4'd10;
  localparam logic [3:0] OFF_HIGH_0   = 4'd11;
  localparam logic [3:0] OFF_PERIOD_3 = 4'd12;
  localparam logic [3:0] OFF_PERIOD_2 = 4'd13;
  localparam logic [3:0] OFF_PERIOD_1 = 4'd14;
  localparam logic [3:0] OFF_PERIOD_0 = 4'd15;

  // Lane 0 is the least significant byte; the offset map stores MSB first, so lane = ~offset[1:0].
  function automatic logic [WIDTH_W-1:0] put_byte(input logic [WIDTH_W-1:0] word,
                                                  input logic [1:0]         lane,
                                                  input logic [BYTE_W-1:0]  value);
    logic [WIDTH_W-1:0] result;
    result = word;
    result[lane*BYTE_W +: BYTE_W] = value;
    return result;
  endfunction

  function automatic logic [BYTE_W-1:0] get_byte(input logic [WIDTH_W-1:0] word,
                                                 input logic [1:0]         lane);
    return word[lane*BYTE_W +: BYTE_W];
  endfunction

endpackage

// File: rtl/pg_channel_regs.sv
// One pulse-generator channel: enable/time registers plus width/period, double-buffered
// with commit-at-period-end and validity checking when PG_SHADOW_EN is defined.
module pg_channel_regs
  import pg_regs_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               wr_en,
  input  logic [3:0]         offset,
  input  logic [BYTE_W-1:0]  wdata,
  input  logic               period_end,
  output logic [ENA_W-1:0]   enable,
  output logic [TIME_W-1:0]  usr_time,
  output logic [WIDTH_W-1:0] width_high,
  output logic [WIDTH_W-1:0] width_period,
  output logic               pending,
  output logic               cfg_err,
  output logic [BYTE_W-1:0]  rd_byte
);

  logic [1:0]         lane;
  logic [WIDTH_W-1:0] high_view;
  logic [WIDTH_W-1:0] period_view;

  assign lane = ~offset[1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      enable   <= '0;
      usr_time <= '0;
    end else if (wr_en) begin
      case (offset)
        OFF_ENA:     enable          <= wdata;
        OFF_YEAR_H:  usr_time[55:48] <= wdata;
        OFF_YEAR_L:  usr_time[47:40] <= wdata;
        OFF_MONTH:   usr_time[39:32] <= wdata;
        OFF_DAY:     usr_time[31:24] <= wdata;
        OFF_HOUR:    usr_time[23:16] <= wdata;
        OFF_MINUTES: usr_time[15:8]  <= wdata;
        OFF_SECONDS: usr_time[7:0]   <= wdata;
        default: ;
      endcase
    end
  end

`ifdef PG_SHADOW_EN
  logic [WIDTH_W-1:0] shadow_high;
  logic [WIDTH_W-1:0] shadow_period;
  logic               lsb_write;
  logic               commit;
  logic               valid;

  assign lsb_write = wr_en && ((offset == OFF_HIGH_0) || (offset == OFF_PERIOD_0));
  assign commit    = pending && (period_end || !enable[0]);
  assign valid     = (shadow_high < shadow_period) && (shadow_period != '0);

  // Commit samples the pre-edge shadow, so a same-edge LSB write re-arms for the next boundary.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shadow_high   <= '0;
      shadow_period <= '0;
      width_high    <= '0;
      width_period  <= '0;
      pending       <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      if (wr_en) begin
        case (offset)
          OFF_HIGH_3, OFF_HIGH_2, OFF_HIGH_1, OFF_HIGH_0:
            shadow_high <= put_byte(shadow_high, lane, wdata);
          OFF_PERIOD_3, OFF_PERIOD_2, OFF_PERIOD_1, OFF_PERIOD_0:
            shadow_period <= put_byte(shadow_period, lane, wdata);
          default: ;
        endcase
      end
      if (commit && valid) begin
        width_high   <= shadow_high;
        width_period <= shadow_period;
      end
      if (lsb_write) begin
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
      if (commit && !valid) begin
        cfg_err <= 1'b1;
      end else if (wr_en && (offset == OFF_ENA)) begin
        cfg_err <= 1'b0;
      end
    end
  end

  assign high_view   = shadow_high;
  assign period_view = shadow_period;
`else
  logic unused_period_end;

  assign unused_period_end = period_end;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      width_high   <= '0;
      width_period <= '0;
    end else if (wr_en) begin
      case (offset)
        OFF_HIGH_3, OFF_HIGH_2, OFF_HIGH_1, OFF_HIGH_0:
          width_high <= put_byte(width_high, lane, wdata);
        OFF_PERIOD_3, OFF_PERIOD_2, OFF_PERIOD_1, OFF_PERIOD_0:
          width_period <= put_byte(width_period, lane, wdata);
        default: ;
      endcase
    end
  end

  assign pending     = 1'b0;
  assign cfg_err     = 1'b0;
  assign high_view   = width_high;
  assign period_view = width_period;
`endif

  always_comb begin
    rd_byte = '0;
    case (offset)
      OFF_ENA:     rd_byte = enable;
      OFF_YEAR_H:  rd_byte = usr_time[55:48];
      OFF_YEAR_L:  rd_byte = usr_time[47:40];
      OFF_MONTH:   rd_byte = usr_time[39:32];
      OFF_DAY:     rd_byte = usr_time[31:24];
      OFF_HOUR:    rd_byte = usr_time[23:16];
      OFF_MINUTES: rd_byte = usr_time[15:8];
      OFF_SECONDS: rd_byte = usr_time[7:0];
      OFF_HIGH_3, OFF_HIGH_2, OFF_HIGH_1, OFF_HIGH_0:
        rd_byte = get_byte(high_view, lane);
      default:     rd_byte = get_byte(period_view, lane);
    endcase
  end

endmodule

// File: rtl/pg_multi_channel_regs.sv
// Register bank for NUM_CH pulse-generator channels on the 8-bit bus: address decode,
// per-channel register instances and the registered read mux. Double-buffering via PG_SHADOW_EN.
module pg_multi_channel_regs
  import pg_regs_pkg::*;
#(
  parameter int                    NUM_CH     = 4,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 8'h40
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_wr,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_data,
  output logic [DATA_WIDTH-1:0]   o_data,
  input  logic [NUM_CH-1:0]       i_period_end,
  output logic [NUM_CH*ENA_W-1:0] o_pulse_enable,
  output logic [NUM_CH*TIME_W-1:0] o_usr_time,
  output logic [NUM_CH*WIDTH_W-1:0] o_width_high,
  output logic [NUM_CH*WIDTH_W-1:0] o_width_period,
  output logic [NUM_CH-1:0]       o_pending,
  output logic [NUM_CH-1:0]       o_cfg_err
);

  localparam int unsigned LIMIT = int'(BASE_ADDR) + CH_STRIDE * NUM_CH;

  logic [ADDR_WIDTH:0]   addr_ext;
  logic [ADDR_WIDTH:0]   rel;
  logic                  hit;
  logic                  wr_hit;
  logic [CH_IDX_W-1:0]   ch_sel;
  logic [3:0]            offset;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic [BYTE_W-1:0]     rd_bytes [NUM_CH];

  // One extra address bit keeps the upper window bound representable when the bank ends at the top.
  assign addr_ext = {1'b0, i_addr};
  assign rel      = addr_ext - {1'b0, BASE_ADDR};
  assign hit      = (addr_ext >= {1'b0, BASE_ADDR}) && (addr_ext < (ADDR_WIDTH+1)'(LIMIT));
  assign wr_hit   = i_wr && hit;
  assign ch_sel   = CH_IDX_W'(rel >> 4);
  assign offset   = rel[3:0];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pg_channel_regs u_ch (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .wr_en        (wr_hit && (ch_sel == CH_IDX_W'(c))),
      .offset       (offset),
      .wdata        (i_data),
      .period_end   (i_period_end[c]),
      .enable       (o_pulse_enable[c*ENA_W +: ENA_W]),
      .usr_time     (o_usr_time[c*TIME_W +: TIME_W]),
      .width_high   (o_width_high[c*WIDTH_W +: WIDTH_W]),
      .width_period (o_width_period[c*WIDTH_W +: WIDTH_W]),
      .pending      (o_pending[c]),
      .cfg_err      (o_cfg_err[c]),
      .rd_byte      (rd_bytes[c])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel == CH_IDX_W'(c)) begin
        rd_mux = rd_bytes[c];
      end
    end
  end

  // Write cycles and unmapped reads both return zero on the following edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data <= '0;
    end else if (!i_wr && hit) begin
      o_data <= rd_mux;
    end else begin
      o_data <= '0;
    end
  end

endmodule
